// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=3, rate-1/2 (7/5 octal) convolutional code.
// The BMU reference model uses the same trellis_sym() so encoder and decoder labels cannot drift.
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned SYM_W      = 2;

    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;

    localparam logic [STATE_W-1:0] S0 = 2'b00;
    localparam logic [STATE_W-1:0] S1 = 2'b01;
    localparam logic [STATE_W-1:0] S2 = 2'b10;
    localparam logic [STATE_W-1:0] S3 = 2'b11;

    typedef logic [STATE_W-1:0] trellis_state_t;
    typedef logic [SYM_W-1:0]   code_sym_t;

    // One output slot: code symbol {c1,c0} plus end-of-frame marker.
    typedef struct packed {
        code_sym_t sym;
        logic      last;
    } sym_beat_t;

    // Window {u,s1,s0} masked by each generator, parity-reduced.
    function automatic code_sym_t trellis_sym(input trellis_state_t state, input logic u);
        logic [K-1:0] win;
        win = {u, state};
        return {^(win & G1), ^(win & G0)};
    endfunction

    function automatic trellis_state_t trellis_next(input trellis_state_t state, input logic u);
        return {u, state[STATE_W-1]};
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder: encodes a FRAME_LEN-bit frame, then flushes
// the trellis back to S0 with zero tail bits, through a single registered output slot.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned TAIL_LEN  = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output logic             sym_last_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int unsigned TCNT_W = 2;

    typedef enum logic [1:0] {IDLE, ENC, TAIL, DRAIN} fsm_e;

    fsm_e              state_q, state_d;
    trellis_state_t    shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TCNT_W-1:0] tail_cnt_q, tail_cnt_d;
    sym_beat_t         slot_q, slot_d;
    logic              sym_valid_q, sym_valid_d;
    logic              busy_q, busy_d;

    logic slot_free, sym_hs, accept, last_bit, last_tail;
    logic load, load_u, load_last;

    assign slot_free = ~sym_valid_q | sym_ready_i;
    assign sym_hs    = sym_valid_q & sym_ready_i;
    assign accept    = (state_q == ENC) & din_valid_i & slot_free;
    assign last_bit  = (bit_cnt_q == CNT_W'(FRAME_LEN - 1));
    assign last_tail = (tail_cnt_q == TCNT_W'(TAIL_LEN - 1));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ENC;
            ENC:     if (accept && last_bit) state_d = TAIL;
            TAIL:    if (slot_free && last_tail) state_d = DRAIN;
            DRAIN:   if (sym_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: decides what, if anything, loads into the slot this cycle
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        slot_d      = slot_q;
        sym_valid_d = sym_valid_q & ~sym_ready_i;
        busy_d      = busy_q;
        din_ready_o = 1'b0;
        load        = 1'b0;
        load_u      = 1'b0;
        load_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d    = S0;
                    bit_cnt_d  = '0;
                    tail_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ENC: begin
                din_ready_o = slot_free;
                if (accept) begin
                    load      = 1'b1;
                    load_u    = din_i;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (last_bit) tail_cnt_d = '0;
                end
            end
            TAIL: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_last  = last_tail;
                    tail_cnt_d = tail_cnt_q + TCNT_W'(1);
                end
            end
            DRAIN: begin
                if (sym_hs) begin
                    slot_d.last = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase

        if (load) begin
            slot_d.sym  = trellis_sym(shift_q, load_u);
            slot_d.last = load_last;
            sym_valid_d = 1'b1;
            shift_d     = trellis_next(shift_q, load_u);
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q     <= S0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            slot_q      <= '0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            slot_q      <= slot_d;
            sym_valid_q <= sym_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sym_o       = slot_q.sym;
    assign sym_last_o  = slot_q.last;
    assign sym_valid_o = sym_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: convolution-level model with per-cycle compare on a FRAME_LEN=4
// instance, plus a FRAME_LEN=16 instance for the all-zero gapped-input frame.
module tb_conv_encoder;

    localparam int unsigned FL = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start, din, din_valid, din_ready, sym_valid, sym_ready, sym_last, busy;
    logic [1:0] sym;
    logic       start_b, din_b, din_valid_b, din_ready_b, sym_valid_b, sym_ready_b, sym_last_b, busy_b;
    logic [1:0] sym_b;

    conv_encoder #(.FRAME_LEN(FL), .TAIL_LEN(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .din_i(din), .din_valid_i(din_valid),
        .din_ready_o(din_ready), .sym_o(sym), .sym_valid_o(sym_valid), .sym_ready_i(sym_ready),
        .sym_last_o(sym_last), .busy_o(busy)
    );

    conv_encoder #(.FRAME_LEN(16), .TAIL_LEN(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .din_i(din_b), .din_valid_i(din_valid_b),
        .din_ready_o(din_ready_b), .sym_o(sym_b), .sym_valid_o(sym_valid_b), .sym_ready_i(sym_ready_b),
        .sym_last_o(sym_last_b), .busy_o(busy_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: symbols follow from the bit history as c1=u[n]^u[n-1]^u[n-2], c0=u[n]^u[n-2].
    typedef struct {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    exp_t q[$];
    bit   hist[$];
    bit   m_busy = 1'b0;
    int   m_acc  = 0;
    bit   was_busy;
    bit   m_ready;

    logic [1:0] log_sym [0:15];
    logic       log_last[0:15];
    int         log_n = 0;

    function automatic void push_bit(input bit u, input bit last);
        int n;
        bit u1, u2;
        exp_t e;
        n  = hist.size();
        u1 = (n >= 1) ? hist[n-1] : 1'b0;
        u2 = (n >= 2) ? hist[n-2] : 1'b0;
        hist.push_back(u);
        e.sym  = {u ^ u1 ^ u2, u ^ u2};
        e.last = last;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hist.delete();
            m_busy = 1'b0;
            m_acc  = 0;
            chk("rst_sym_valid", sym_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_din_ready", din_ready, 0);
            chk("rst_sym", sym, 0);
            chk("rst_last", sym_last, 0);
        end else begin
            was_busy = m_busy;
            m_ready  = m_busy && (m_acc < FL) && (!sym_valid || sym_ready);
            chk("sym_valid", sym_valid, (q.size() != 0));
            if (sym_valid && q.size() != 0) begin
                chk("sym", sym, q[0].sym);
                chk("sym_last", sym_last, q[0].last);
            end else if (!sym_valid) begin
                chk("last_idle", sym_last, 0);
            end
            chk("busy", busy, m_busy);
            chk("din_ready", din_ready, m_ready);
            if (sym_valid && sym_ready) begin
                if (log_n < 16) begin
                    log_sym[log_n]  = sym;
                    log_last[log_n] = sym_last;
                end
                log_n++;
                if (q.size() != 0) begin
                    if (q[0].last) m_busy = 1'b0;
                    void'(q.pop_front());
                end
            end
            if (din_valid && m_ready) begin
                push_bit(din, 1'b0);
                m_acc++;
                if (m_acc == FL) begin
                    push_bit(1'b0, 1'b0);
                    push_bit(1'b0, 1'b1);
                end
            end
            if (start && !was_busy) begin
                m_busy = 1'b1;
                hist.delete();
                m_acc = 0;
            end
        end
    end

    // mode[0]: stall 3 cycles after symbol 2; mode[1]: pulse start in ENC and TAIL.
    task automatic run_frame(input logic [3:0] bits, input int mode, input int rst_after);
        int  i, stall, pokes;
        bit  done, aborted;
        i = 0; stall = 0; pokes = 0; done = 1'b0; aborted = 1'b0;
        log_n = 0;
        for (int k = 0; k < 16; k++) begin
            log_sym[k]  = 2'bxx;
            log_last[k] = 1'bx;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            din_valid = (i < int'(FL));
            din       = (i < int'(FL)) ? bits[i] : 1'b0;
            sym_ready = 1'b1;
            if (mode[0] && log_n >= 2 && stall < 3) begin
                sym_ready = 1'b0;
                stall++;
            end
            start = 1'b0;
            if (mode[1] && ((i == 2 && pokes == 0) || (i == int'(FL) && pokes == 1))) begin
                start = 1'b1;
                pokes++;
            end
            @(negedge clk);
            if (din_valid && din_ready) i++;
            if (i == rst_after) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                chk("async_rst_valid", sym_valid, 0);
                chk("async_rst_busy", busy, 0);
                chk("async_rst_ready", din_ready, 0);
                chk("async_rst_sym", sym, 0);
                chk("async_rst_last", sym_last, 0);
                din_valid = 1'b0;
                start     = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (!busy && log_n >= 6) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done && !aborted) chk("frame_timeout", 0, 1);
        start     = 1'b0;
        din_valid = 1'b0;
        sym_ready = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [11:0] tbl);
        logic [11:0] t;
        t = tbl;
        chk({tag, "_count"}, log_n, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_sym%0d", tag, k), log_sym[k], t[11-2*k -: 2]);
            chk($sformatf("%s_last%0d", tag, k), log_last[k], (k == 5));
        end
        chk({tag, "_final_state"}, dut.shift_q, 0);
    endtask

    localparam logic [11:0] T1 = 12'b11_10_00_01_01_11;
    localparam logic [11:0] T2 = 12'b00_11_01_10_01_11;

    int  prev_acc, n_acc, n_sym, acc;
    bit  fin;

    initial begin
        rst_n = 1'b0;
        start = 1'b0; din = 1'b0; din_valid = 1'b0; sym_ready = 1'b1;
        start_b = 1'b0; din_b = 1'b0; din_valid_b = 1'b0; sym_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b_rst_valid", sym_valid_b, 0);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_sym", sym_b, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Frame 1,0,1,1 and the sweep frame 0,1,1,1 (bit 0 sent first)
        run_frame(4'b1101, 0, -1);
        check_log("t1", T1);
        run_frame(4'b1110, 0, -1);
        check_log("t2", T2);

        run_frame(4'b1101, 1, -1);
        check_log("t3", T1);

        // All-zero 16-bit frame with din_valid on every other cycle
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        prev_acc = 0; n_acc = 0; n_sym = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
            @(posedge clk); #1;
            din_valid_b = (n_acc < 16) && (cyc % 2 == 0);
            @(negedge clk);
            if (n_acc < 16) chk("t4_gap_valid", sym_valid_b, prev_acc);
            if (sym_valid_b) begin
                n_sym++;
                chk("t4_sym", sym_b, 0);
                chk("t4_last", sym_last_b, (n_sym == 18));
                if (sym_last_b) fin = 1'b1;
            end
            acc      = (din_valid_b && din_ready_b) ? 1 : 0;
            prev_acc = acc;
            n_acc   += acc;
        end
        din_valid_b = 1'b0;
        chk("t4_count", n_sym, 18);
        @(posedge clk);
        @(negedge clk);
        chk("t4_busy_end", busy_b, 0);
        chk("t4_valid_end", sym_valid_b, 0);

        run_frame(4'b1101, 2, -1);
        check_log("t5", T1);

        run_frame(4'b1101, 0, 2);
        run_frame(4'b1101, 0, -1);
        check_log("t6", T1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
